// File: rtl/lcd_readback.sv
`default_nettype none
// ============================================================================
// lcd_readback : HD44780 read cycle (busy flag/address or data) whose captured
//                byte is returned to the host as one 8N1 UART frame on TxD.
// Revision     : 1.0
// ============================================================================
module lcd_readback #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BAUD         = 115200,
  parameter int SETUP_CYCLES = 2,
  parameter int E_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_rs,
  output logic       busy,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  input  logic [7:0] LCD_DataBus_in,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       TxD
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int MAXC     = (SETUP_CYCLES > E_CYCLES) ? SETUP_CYCLES : E_CYCLES;
  localparam int PW       = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] E_LAST     = PW'(E_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST   = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EHIGH = 2'd2,
    TX    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [BW-1:0]   baud_q,  baud_d;
  logic [3:0]      bit_q,   bit_d;
  logic [8:0]      shift_q, shift_d;
  logic            busy_q, busy_d;
  logic            rs_q, rs_d;
  logic            rw_q, rw_d;
  logic            e_q, e_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            txd_q, txd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      e_q        <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      e_q        <= e_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    e_d        = e_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    txd_d      = txd_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          rs_d    = req_rs;
          rw_d    = 1'b1;
          busy_d  = 1'b1;
          phase_d = '0;
        end
      end
      SETUP: begin
        if (phase_q == SETUP_LAST) begin
          state_d = EHIGH;
          e_d     = 1'b1;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      EHIGH: begin
        // Sample on the edge that closes the final E-high clock; start bit begins here too.
        if (phase_q == E_LAST) begin
          state_d    = TX;
          e_d        = 1'b0;
          rd_data_d  = LCD_DataBus_in;
          rd_valid_d = 1'b1;
          shift_d    = {1'b1, LCD_DataBus_in};
          txd_d      = 1'b0;
          baud_d     = '0;
          bit_d      = '0;
          phase_d    = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      TX: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            rw_d    = 1'b0;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[8:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = rw_q;
  assign LCD_E    = e_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign TxD      = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_readback.sv
`default_nettype none
// ============================================================================
// tb_lcd_readback : directed self-checking bench for lcd_readback.
// Revision        : 1.0
// ============================================================================
module tb_lcd_readback;

  localparam int SETUP_CYCLES = 2;
  localparam int E_CYCLES     = 4;
  localparam int BAUD_DIV     = 4;
  localparam int OP_LEN       = SETUP_CYCLES + E_CYCLES + 10 * BAUD_DIV; // 46

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] bus = 8'h00;
  logic       busy, LCD_RS, LCD_RW, LCD_E, rd_valid, TxD;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rd = 8'h00;

  lcd_readback #(
    .CLK_FREQ(16), .BAUD(4), .SETUP_CYCLES(SETUP_CYCLES), .E_CYCLES(E_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_rs(req_rs), .busy(busy),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E),
    .LCD_DataBus_in(bus), .rd_data(rd_data), .rd_valid(rd_valid), .TxD(TxD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag, input int cyc);
    chk({tag, "_busy"}, cyc, {7'd0, busy}, 8'h00);
    chk({tag, "_rs"},   cyc, {7'd0, LCD_RS}, 8'h00);
    chk({tag, "_rw"},   cyc, {7'd0, LCD_RW}, 8'h00);
    chk({tag, "_e"},    cyc, {7'd0, LCD_E}, 8'h00);
    chk({tag, "_rd"},   cyc, rd_data, 8'h00);
    chk({tag, "_vld"},  cyc, {7'd0, rd_valid}, 8'h00);
    chk({tag, "_txd"},  cyc, {7'd0, TxD}, 8'h01);
  endtask

  // One full read: req sampled at the edge before cycle 0; cycles 0..OP_LEN+1
  // are sampled on falling edges. bus switches to d1 after cycle chg_at;
  // optional req pulse at cycle 20 (inside TX) must be ignored.
  task automatic run_op(input logic rs, input logic [7:0] d0, input logic [7:0] d1,
                        input int chg_at, input bit pulse_tx);
    logic [9:0] frame;
    logic [7:0] cap;
    logic       exp_e, exp_b, exp_t;
    cap   = (chg_at >= 0) ? d1 : d0;
    frame = {1'b1, cap, 1'b0};
    req = 1'b1; req_rs = rs; bus = d0;
    for (int i = 0; i < OP_LEN + 2; i++) begin
      @(negedge clk);
      if (i == 0) begin req = 1'b0; req_rs = ~rs; end
      exp_e = (i >= SETUP_CYCLES) && (i < SETUP_CYCLES + E_CYCLES);
      exp_b = (i < OP_LEN);
      if (i < SETUP_CYCLES + E_CYCLES || i >= OP_LEN) exp_t = 1'b1;
      else exp_t = frame[(i - SETUP_CYCLES - E_CYCLES) / BAUD_DIV];
      if (i == SETUP_CYCLES + E_CYCLES) exp_rd = cap;
      chk("e",    i, {7'd0, LCD_E}, {7'd0, exp_e});
      chk("busy", i, {7'd0, busy}, {7'd0, exp_b});
      chk("rw",   i, {7'd0, LCD_RW}, {7'd0, exp_b});
      chk("rs",   i, {7'd0, LCD_RS}, {7'd0, rs});
      chk("txd",  i, {7'd0, TxD}, {7'd0, exp_t});
      chk("vld",  i, {7'd0, rd_valid}, {7'd0, (i == SETUP_CYCLES + E_CYCLES)});
      chk("rd",   i, rd_data, exp_rd);
      if (i == chg_at) bus = d1;
      if (pulse_tx && i == 20) req = 1'b1;
      if (pulse_tx && i == 21) req = 1'b0;
    end
  endtask

  initial begin
    int m;
    int waited;
    logic [9:0] frame;

    // Reset held with req asserted: no activity may start.
    rst = 1'b1; req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle_reset("rst", i);
    end
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk_idle_reset("post_rst", 0);

    // Busy-flag read, then data read, then a read with a req pulse inside TX.
    run_op(1'b0, 8'h8A, 8'h8A, -1, 1'b0);
    run_op(1'b1, 8'hFF, 8'hFF, -1, 1'b0);
    run_op(1'b0, 8'h3C, 8'h3C, -1, 1'b1);

    // Bus changes during the third E-high clock; only the last one is sampled.
    run_op(1'b1, 8'h00, 8'h55, SETUP_CYCLES + 2, 1'b0);

    // req held high: back-to-back operations with exactly one IDLE clock.
    req = 1'b1; req_rs = 1'b0; bus = 8'hA5;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      m = i % (OP_LEN + 1);
      chk("hold_busy", i, {7'd0, busy}, {7'd0, (m != OP_LEN)});
      chk("hold_e",    i, {7'd0, LCD_E},
          {7'd0, (m >= SETUP_CYCLES && m < SETUP_CYCLES + E_CYCLES)});
    end
    req = 1'b0;
    waited = 0;
    while (busy === 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("hold_drain", waited, {7'd0, busy}, 8'h00);
    exp_rd = 8'hA5;
    chk("hold_rd", 0, rd_data, 8'hA5);

    // Reset mid-frame during data bit 3 (frame bit 4).
    frame = {1'b1, 8'h96, 1'b0};
    req = 1'b1; req_rs = 1'b1; bus = 8'h96;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) req = 1'b0;
    end
    chk("pre_abort_txd", 23, {7'd0, TxD}, {7'd0, frame[4]});
    chk("pre_abort_busy", 23, {7'd0, busy}, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_reset("abort", 0);
    rst = 1'b0;
    exp_rd = 8'h00;
    run_op(1'b1, 8'hC3, 8'hC3, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
